mips_harvard_mem_responder: RTL and testbench
=============================================

# mips_harvard_mem_responder

Memory-side responder for the Harvard MIPS CPU bus: serves the CPU's combinational instruction-fetch port and its data port (combinational read, single-cycle write) from two internal word arrays. Inserts a programmable number of wait states on every data access by driving the CPU's `clk_enable` low. Also provides a side-band load port for preloading program and data images, and a sticky fault flag for out-of-range accesses. Sits in the testbench/SoC wrapper directly opposite the CPU.

## Interface
- `INSTR_BASE`, 32'hBFC00000, byte address of instruction word 0.
- `INSTR_WORDS`, 1024, instruction array depth in 32-bit words.
- `DATA_BASE`, 32'h00000000, byte address of data word 0.
- `DATA_WORDS`, 1024, data array depth in 32-bit words.
- `WAIT_CYCLES`, 0, stall cycles inserted per data access (0..15).

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `clk_enable` out 1: CPU advance enable; low means the CPU must hold.
- `instr_address` in 32: CPU fetch byte address.
- `instr_readdata` out 32: fetched word, combinational.
- `data_address` in 32: CPU data byte address, word aligned.
- `data_read` in 1: read request.
- `data_write` in 1: write request.
- `data_writedata` in 32: write data.
- `data_readdata` out 32: read data, combinational.
- `prog_write` in 1: load-port write strobe.
- `prog_sel` in 1: 0 = instruction array, 1 = data array.
- `prog_addr` in 32: load-port word index (not byte address).
- `prog_data` in 32: load-port write data.
- `fault` out 1: sticky out-of-range/protocol error flag.

## Operation
- Decode: index = (address − BASE) >> 2, 32-bit unsigned subtraction, wraps; in range iff index < WORDS. Bits [1:0] are ignored.
- Instruction port: `instr_readdata` = instr array[index] when in range, else 0. An out-of-range fetch sets `fault`, except fetch of address 0, which is the CPU's halt address and returns 0 without a fault.
- Data read: `data_readdata` = data array[index] when in range and `data_read`=1, else 0. An out-of-range read sets `fault`.
- Data write: commits data array[index] <= `data_writedata` only on the edge where `data_write`=1 and `clk_enable`=1, so exactly one commit happens per access. An out-of-range write is dropped and sets `fault`.
- `data_read` and `data_write` both high in the same cycle: treated as a write, and `fault` is set.
- Load port: when `prog_write`=1, writes the selected array at `prog_addr` on the edge. An out-of-range `prog_addr` is dropped and sets `fault`. If it hits the same data word as a committing CPU write in the same cycle, the load port wins.
- Wait-state FSM, states IDLE and WAIT, with a 4-bit counter `cnt`:
  - IDLE: access = `data_read`|`data_write`. If access and WAIT_CYCLES>0: `clk_enable`=0, cnt <= WAIT_CYCLES−1, next state WAIT. Otherwise `clk_enable`=1 and the FSM stays in IDLE.
  - WAIT: `clk_enable` = (cnt==0). If cnt==0, next state IDLE; else cnt <= cnt−1.
  - The request signals are not re-sampled in WAIT; the CPU holds them stable while stalled.
- Reset: state IDLE, cnt 0, `fault` 0. Array contents are not cleared. A reset during WAIT abandons the access, and no write is committed.

## Timing
- Reset values: `clk_enable` 1 (combinationally from IDLE with no access), `fault` 0. `instr_readdata` and `data_readdata` are combinational from the arrays.
- Read latency is 0 cycles: data is valid in the same cycle as the address.
- Write latency is 1 edge: a read of the same word in the following cycle returns the new value.
- Per data access, `clk_enable` is low for exactly WAIT_CYCLES consecutive cycles, then high for 1 cycle. The CPU advances on that (WAIT_CYCLES+1)th edge.
- Back-to-back accesses: after WAIT returns to IDLE, the next access stalls again immediately, with no dead cycle.
- WAIT_CYCLES=0: `clk_enable` is tied high in function, and the FSM never leaves IDLE.
- `fault` sets on the edge following the offending cycle and holds until `reset`.

## Test plan
- Preload: load port writes instr[0]=32'h24020005 and data[3]=32'hDEADBEEF. Then instr_address=32'hBFC00000 → instr_readdata=32'h24020005, and data_address=32'h0000000C with data_read=1 → data_readdata=32'hDEADBEEF in the same cycle. `fault` stays 0.
- Write/readback: data_write=1, address 32'h10, data 32'h12345678, WAIT_CYCLES=0. Next cycle a read of 32'h10 → 32'h12345678, and `clk_enable` stays 1 throughout.
- Wait states: with WAIT_CYCLES=3, hold data_write=1 at 32'h20 with data 32'hA5A5A5A5. `clk_enable` must be 0,0,0,1, and exactly one commit occurs on the 4th edge. A write of the same word via the load port 2 cycles in is overwritten by the CPU commit on edge 4 only if it precedes it; if simultaneous, the load port value is kept.
- Faults: data read of 32'h00001000 with DATA_WORDS=1024 → data_readdata=0 and `fault`=1 on the next cycle. A fetch at 32'h00000000 → 0 with `fault` unchanged. Read and write asserted together → write commits and `fault`=1.
- Reset mid-stall: with WAIT_CYCLES=5, assert reset on the 2nd stall cycle. The word is unchanged, `clk_enable`=1 and `fault`=0 after reset, and a new access stalls for the full 5 cycles.

Source files
------------

// File: rtl/mips_harvard_mem_responder_if.sv
// Bus between the Harvard MIPS CPU (master) and its memory responder (slave),
// carrying the fetch port, the data port, the side-band load port and the fault flag.
interface mips_harvard_mem_responder_if;
  logic        clk_enable;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic        prog_write;
  logic        prog_sel;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
  logic        fault;

  modport slave (
    output clk_enable,
    input  instr_address,
    output instr_readdata,
    input  data_address,
    input  data_read,
    input  data_write,
    input  data_writedata,
    output data_readdata,
    input  prog_write,
    input  prog_sel,
    input  prog_addr,
    input  prog_data,
    output fault
  );

  modport master (
    input  clk_enable,
    output instr_address,
    input  instr_readdata,
    output data_address,
    output data_read,
    output data_write,
    output data_writedata,
    input  data_readdata,
    output prog_write,
    output prog_sel,
    output prog_addr,
    output prog_data,
    input  fault
  );
endinterface

// File: rtl/mips_harvard_mem_responder.sv
// Memory responder facing the Harvard MIPS CPU: combinational instruction and data
// reads, stalled single-commit data writes, a preload port and a sticky fault flag.
module mips_harvard_mem_responder #(
  parameter logic [31:0] INSTR_BASE  = 32'hBFC00000,
  parameter int          INSTR_WORDS = 1024,
  parameter logic [31:0] DATA_BASE   = 32'h00000000,
  parameter int          DATA_WORDS  = 1024,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  mips_harvard_mem_responder_if.slave        bus
);

  localparam int         IAW       = (INSTR_WORDS > 1) ? $clog2(INSTR_WORDS) : 1;
  localparam int         DAW       = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
  localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_fault;
  logic [31:0] r_instrMem [INSTR_WORDS];
  logic [31:0] r_dataMem  [DATA_WORDS];

  logic [31:0] w_instrDiff;
  logic [31:0] w_dataDiff;
  logic [29:0] w_instrIdx;
  logic [29:0] w_dataIdx;
  logic        w_instrInRange;
  logic        w_dataInRange;
  logic        w_progInRange;
  logic        w_access;
  logic        w_clkEnable;
  logic        w_cpuCommit;
  logic        w_progInstr;
  logic        w_progData;
  logic        w_faultEvent;
  logic        w_unused;

  // Address decode: wrapping subtraction, so addresses below BASE land far out of range.
  assign w_instrDiff    = bus.instr_address - INSTR_BASE;
  assign w_dataDiff     = bus.data_address - DATA_BASE;
  assign w_instrIdx     = w_instrDiff[31:2];
  assign w_dataIdx      = w_dataDiff[31:2];
  assign w_instrInRange = ({2'b00, w_instrIdx} < 32'(INSTR_WORDS));
  assign w_dataInRange  = ({2'b00, w_dataIdx} < 32'(DATA_WORDS));
  assign w_progInRange  = bus.prog_sel ? (bus.prog_addr < 32'(DATA_WORDS))
                                       : (bus.prog_addr < 32'(INSTR_WORDS));
  assign w_unused       = ^{w_instrDiff[1:0], w_dataDiff[1:0]};

  assign bus.instr_readdata = w_instrInRange ? r_instrMem[w_instrIdx[IAW-1:0]] : 32'd0;
  assign bus.data_readdata  = (w_dataInRange && bus.data_read) ? r_dataMem[w_dataIdx[DAW-1:0]]
                                                               : 32'd0;

  assign w_access = bus.data_read | bus.data_write;

  always_comb begin
    w_clkEnable = 1'b1;
    case (r_state)
      S_IDLE:  w_clkEnable = !(w_access && HAS_WAIT);
      S_WAIT:  w_clkEnable = (r_cnt == 4'd0);
      default: w_clkEnable = 1'b1;
    endcase
  end

  assign bus.clk_enable = w_clkEnable;

  // The CPU write lands only on the edge the CPU itself advances on; reset abandons it.
  assign w_cpuCommit = bus.data_write && w_clkEnable && w_dataInRange && !reset;
  assign w_progInstr = bus.prog_write && !bus.prog_sel && w_progInRange;
  assign w_progData  = bus.prog_write && bus.prog_sel && w_progInRange;

  // The load port is written last so it wins a same-word collision with the CPU.
  always_ff @(posedge clk) begin
    if (w_cpuCommit) begin
      r_dataMem[w_dataIdx[DAW-1:0]] <= bus.data_writedata;
    end
    if (w_progData) begin
      r_dataMem[bus.prog_addr[DAW-1:0]] <= bus.prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_progInstr) begin
      r_instrMem[bus.prog_addr[IAW-1:0]] <= bus.prog_data;
    end
  end

  // Wait-state sequencer; requests are held by the stalled CPU, so WAIT ignores them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_access && HAS_WAIT) begin
            r_cnt   <= WAIT_LOAD;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Address 0 is the CPU halt address, so fetching it is not an error.
  assign w_faultEvent = (!w_instrInRange && (bus.instr_address != 32'd0))
                     || (w_access && !w_dataInRange)
                     || (bus.data_read && bus.data_write)
                     || (bus.prog_write && !w_progInRange);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fault <= 1'b0;
    end else if (w_faultEvent) begin
      r_fault <= 1'b1;
    end
  end

  assign bus.fault = r_fault;

endmodule

// File: tb/tb_mips_harvard_mem_responder.sv
// Bench for the MIPS memory responder: a vector table on a zero-wait instance plus
// stall sequences on 3- and 5-wait instances, all checked through an expectation queue.
module tb_mips_harvard_mem_responder;

  logic clk = 1'b0;
  logic rst0;
  logic rst3;
  logic rst5;
  int   checks   = 0;
  int   failures = 0;

  mips_harvard_mem_responder_if bus0 ();
  mips_harvard_mem_responder_if bus3 ();
  mips_harvard_mem_responder_if bus5 ();

  mips_harvard_mem_responder #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .reset(rst0), .bus(bus0));
  mips_harvard_mem_responder #(.WAIT_CYCLES(3)) dut3 (.clk(clk), .reset(rst3), .bus(bus3));
  mips_harvard_mem_responder #(.WAIT_CYCLES(5)) dut5 (.clk(clk), .reset(rst5), .bus(bus5));

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] value;
  } exp_t;

  typedef struct {
    string       name;
    logic        doReset;
    logic        progWrite;
    logic        progSel;
    logic [31:0] progAddr;
    logic [31:0] progData;
    logic [31:0] instrAddr;
    logic [31:0] dataAddr;
    logic        dataRead;
    logic        dataWrite;
    logic [31:0] writeData;
    logic [31:0] expInstr;
    logic [31:0] expRead;
    logic        expCe;
    logic        expFault;
  } vec_t;

  exp_t expQ[$];
  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic doReset,
                              input logic pw, input logic ps, input logic [31:0] pa,
                              input logic [31:0] pd, input logic [31:0] ia,
                              input logic [31:0] da, input logic rd, input logic wr,
                              input logic [31:0] wd, input logic [31:0] ei,
                              input logic [31:0] er, input logic ece, input logic ef);
    vec_t v;
    v.name = name; v.doReset = doReset;
    v.progWrite = pw; v.progSel = ps; v.progAddr = pa; v.progData = pd;
    v.instrAddr = ia; v.dataAddr = da; v.dataRead = rd; v.dataWrite = wr;
    v.writeData = wd; v.expInstr = ei; v.expRead = er; v.expCe = ece; v.expFault = ef;
    return v;
  endfunction

  task automatic pushExp(input string name, input logic [31:0] value);
    exp_t e;
    e.name  = name;
    e.value = value;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] actual);
    exp_t e;
    checks++;
    if (expQ.size() == 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_empty actual=%h", actual);
    end else begin
      e = expQ.pop_front();
      if (actual !== e.value) begin
        failures++;
        $display("[TB] FAIL %s actual=%h expected=%h", e.name, actual, e.value);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleBus0();
    bus0.instr_address  = 32'd0;
    bus0.data_address   = 32'd0;
    bus0.data_read      = 1'b0;
    bus0.data_write     = 1'b0;
    bus0.data_writedata = 32'd0;
    bus0.prog_write     = 1'b0;
    bus0.prog_sel       = 1'b0;
    bus0.prog_addr      = 32'd0;
    bus0.prog_data      = 32'd0;
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.doReset) begin
      idleBus0();
      rst0 = 1'b1;
      tick();
      rst0 = 1'b0;
    end
    bus0.prog_write     = v.progWrite;
    bus0.prog_sel       = v.progSel;
    bus0.prog_addr      = v.progAddr;
    bus0.prog_data      = v.progData;
    bus0.instr_address  = v.instrAddr;
    bus0.data_address   = v.dataAddr;
    bus0.data_read      = v.dataRead;
    bus0.data_write     = v.dataWrite;
    bus0.data_writedata = v.writeData;
    pushExp({v.name, ".instr"}, v.expInstr);
    pushExp({v.name, ".rdata"}, v.expRead);
    pushExp({v.name, ".ce"}, {31'd0, v.expCe});
    pushExp({v.name, ".fault"}, {31'd0, v.expFault});
    @(negedge clk);
    checkOutput(bus0.instr_readdata);
    checkOutput(bus0.data_readdata);
    checkOutput({31'd0, bus0.clk_enable});
    tick();
    checkOutput({31'd0, bus0.fault});
  endtask

  initial begin
    rst0 = 1'b1; rst3 = 1'b1; rst5 = 1'b1;
    idleBus0();
    bus3.instr_address = 32'd0; bus3.data_address = 32'd0; bus3.data_read = 1'b0;
    bus3.data_write = 1'b0; bus3.data_writedata = 32'd0; bus3.prog_write = 1'b0;
    bus3.prog_sel = 1'b0; bus3.prog_addr = 32'd0; bus3.prog_data = 32'd0;
    bus5.instr_address = 32'd0; bus5.data_address = 32'd0; bus5.data_read = 1'b0;
    bus5.data_write = 1'b0; bus5.data_writedata = 32'd0; bus5.prog_write = 1'b0;
    bus5.prog_sel = 1'b0; bus5.prog_addr = 32'd0; bus5.prog_data = 32'd0;
    tick();
    tick();
    rst0 = 1'b0; rst3 = 1'b0; rst5 = 1'b0;

    //              name         rst pw ps prog_addr  prog_data      instr_addr     data_addr      rd wr write_data     exp_instr      exp_read       ce f
    vecs.push_back(mk("reset",     1, 0, 0, 32'd0,    32'd0,         32'd0,         32'd0,         0, 0, 32'd0,         32'd0,         32'd0,         1, 0));
    vecs.push_back(mk("load_i0",   0, 1, 0, 32'd0,    32'h24020005,  32'd0,         32'd0,         0, 0, 32'd0,         32'd0,         32'd0,         1, 0));
    vecs.push_back(mk("load_d3",   0, 1, 1, 32'd3,    32'hDEADBEEF,  32'hBFC00000,  32'd0,         0, 0, 32'd0,         32'h24020005,  32'd0,         1, 0));
    vecs.push_back(mk("preload",   0, 0, 0, 32'd0,    32'd0,         32'hBFC00000,  32'h0000000C,  1, 0, 32'd0,         32'h24020005,  32'hDEADBEEF,  1, 0));
    vecs.push_back(mk("wr_10",     0, 0, 0, 32'd0,    32'd0,         32'd0,         32'h00000010,  0, 1, 32'h12345678,  32'd0,         32'd0,         1, 0));
    vecs.push_back(mk("rd_10",     0, 0, 0, 32'd0,    32'd0,         32'd0,         32'h00000010,  1, 0, 32'd0,         32'd0,         32'h12345678,  1, 0));
    vecs.push_back(mk("ld_vs_cpu", 0, 1, 1, 32'd5,    32'h55555555,  32'd0,         32'h00000014,  0, 1, 32'h66666666,  32'd0,         32'd0,         1, 0));
    vecs.push_back(mk("rd_14",     0, 0, 0, 32'd0,    32'd0,         32'd0,         32'h00000014,  1, 0, 32'd0,         32'd0,         32'h55555555,  1, 0));
    vecs.push_back(mk("wr_18",     0, 0, 0, 32'd0,    32'd0,         32'd0,         32'h00000018,  0, 1, 32'h11111111,  32'd0,         32'd0,         1, 0));
    vecs.push_back(mk("fetch0",    0, 0, 0, 32'd0,    32'd0,         32'd0,         32'h00000018,  1, 0, 32'd0,         32'd0,         32'h11111111,  1, 0));
    vecs.push_back(mk("oor_read",  0, 0, 0, 32'd0,    32'd0,         32'd0,         32'h00001000,  1, 0, 32'd0,         32'd0,         32'd0,         1, 1));
    vecs.push_back(mk("sticky",    0, 0, 0, 32'd0,    32'd0,         32'hBFC00000,  32'd0,         0, 0, 32'd0,         32'h24020005,  32'd0,         1, 1));
    vecs.push_back(mk("rdwr",      1, 0, 0, 32'd0,    32'd0,         32'd0,         32'h00000018,  1, 1, 32'h77777777,  32'd0,         32'h11111111,  1, 1));
    vecs.push_back(mk("rd_18",     0, 0, 0, 32'd0,    32'd0,         32'd0,         32'h00000018,  1, 0, 32'd0,         32'd0,         32'h77777777,  1, 1));
    vecs.push_back(mk("oor_fetch", 1, 0, 0, 32'd0,    32'd0,         32'hBFC01000,  32'd0,         0, 0, 32'd0,         32'd0,         32'd0,         1, 1));
    vecs.push_back(mk("oor_progd", 1, 1, 1, 32'd1024, 32'h0,         32'd0,         32'd0,         0, 0, 32'd0,         32'd0,         32'd0,         1, 1));
    vecs.push_back(mk("oor_write", 1, 0, 0, 32'd0,    32'd0,         32'd0,         32'h00001000,  0, 1, 32'h0,         32'd0,         32'd0,         1, 1));
    vecs.push_back(mk("oor_progi", 1, 1, 0, 32'd1024, 32'h0,         32'd0,         32'd0,         0, 0, 32'd0,         32'd0,         32'd0,         1, 1));
    vecs.push_back(mk("wrap_read", 1, 0, 0, 32'd0,    32'd0,         32'd0,         32'hFFFFFFFC,  1, 0, 32'd0,         32'd0,         32'd0,         1, 1));

    foreach (vecs[i]) applyStimulus(vecs[i]);
    idleBus0();

    // Three-wait write, with an earlier load-port write to the same word overwritten.
    bus3.prog_write = 1'b1; bus3.prog_sel = 1'b1; bus3.prog_addr = 32'd8; bus3.prog_data = 32'd0;
    tick();
    bus3.data_address = 32'h20; bus3.data_writedata = 32'hA5A5A5A5; bus3.data_write = 1'b1;
    bus3.prog_data = 32'h11111111;
    for (int c = 0; c < 4; c++) begin
      bus3.prog_write = (c == 1);
      pushExp($sformatf("ws_a.ce%0d", c), {31'd0, (c == 3)});
      @(negedge clk);
      checkOutput({31'd0, bus3.clk_enable});
      tick();
    end
    bus3.prog_write = 1'b0; bus3.data_write = 1'b0; bus3.data_read = 1'b1;
    for (int c = 0; c < 4; c++) begin
      pushExp($sformatf("ws_rd.ce%0d", c), {31'd0, (c == 3)});
      pushExp($sformatf("ws_rd.data%0d", c), 32'hA5A5A5A5);
      @(negedge clk);
      checkOutput({31'd0, bus3.clk_enable});
      checkOutput(bus3.data_readdata);
      tick();
    end

    // Load-port write on the commit edge itself keeps the load-port value.
    bus3.data_read = 1'b0; bus3.data_write = 1'b1; bus3.data_writedata = 32'hC3C3C3C3;
    bus3.prog_data = 32'h22222222;
    for (int c = 0; c < 4; c++) begin
      bus3.prog_write = (c == 3);
      pushExp($sformatf("ws_b.ce%0d", c), {31'd0, (c == 3)});
      @(negedge clk);
      checkOutput({31'd0, bus3.clk_enable});
      tick();
    end
    bus3.prog_write = 1'b0; bus3.data_write = 1'b0; bus3.data_read = 1'b1;
    pushExp("ws_b.readback", 32'h22222222);
    pushExp("ws.fault", 32'd0);
    @(negedge clk);
    checkOutput(bus3.data_readdata);
    checkOutput({31'd0, bus3.fault});
    for (int c = 0; c < 4; c++) tick();
    bus3.data_read = 1'b0;

    // Reset on the second stall cycle of a five-wait write abandons it.
    bus5.prog_write = 1'b1; bus5.prog_sel = 1'b1; bus5.prog_addr = 32'd10;
    bus5.prog_data = 32'hCAFEF00D;
    tick();
    bus5.prog_write = 1'b0;
    bus5.data_address = 32'h28; bus5.data_writedata = 32'h0BADF00D; bus5.data_write = 1'b1;
    pushExp("rst.stall1", 32'd0);
    @(negedge clk);
    checkOutput({31'd0, bus5.clk_enable});
    tick();
    pushExp("rst.stall2", 32'd0);
    @(negedge clk);
    checkOutput({31'd0, bus5.clk_enable});
    rst5 = 1'b1;
    bus5.data_write = 1'b0;
    tick();
    rst5 = 1'b0;
    pushExp("rst.ce_after", 32'd1);
    pushExp("rst.fault_after", 32'd0);
    @(negedge clk);
    checkOutput({31'd0, bus5.clk_enable});
    checkOutput({31'd0, bus5.fault});
    tick();
    bus5.data_read = 1'b1;
    for (int c = 0; c < 6; c++) begin
      pushExp($sformatf("rst_rd.ce%0d", c), {31'd0, (c == 5)});
      pushExp($sformatf("rst_rd.data%0d", c), 32'hCAFEF00D);
      @(negedge clk);
      checkOutput({31'd0, bus5.clk_enable});
      checkOutput(bus5.data_readdata);
      tick();
    end
    bus5.data_read = 1'b0;

    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_leftover actual=%0d expected=0", expQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
